// File: rtl/bankmem_arbiter.sv
// Two-master arbiter for the single-port BankedMEM data memory, with lock/timeout ownership.
// Define BANKMEM_ARB_RR_EN for round-robin tie breaking in IDLE; otherwise master 0 has fixed priority.
module bankmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0Req,
  input  logic              m0WriteEn,
  input  logic              m0Lock,
  input  logic [ADDR_W-1:0] m0Address,
  input  logic [DATA_W-1:0] m0WriteData,
  input  logic              m1Req,
  input  logic              m1WriteEn,
  input  logic              m1Lock,
  input  logic [ADDR_W-1:0] m1Address,
  input  logic [DATA_W-1:0] m1WriteData,
  output logic              m0Gnt,
  output logic              m1Gnt,
  output logic              m0RValid,
  output logic              m1RValid,
  output logic [DATA_W-1:0] m0RData,
  output logic [DATA_W-1:0] m1RData,
  output logic              memWriteEn,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  input  logic [DATA_W-1:0] memReadData
);

  localparam int CNT_W = $clog2(MAX_LOCK) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t              state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic                m0_rvalid_q, m0_rvalid_d;
  logic                m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic [CNT_W-1:0]    lock_cnt_inc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      lock_cnt_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      lock_cnt_q  <= lock_cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  // Output logic: grants are gated by rst_n so nothing reaches the memory during reset
  always_comb begin
    m0Gnt        = 1'b0;
    m1Gnt        = 1'b0;
    memWriteEn   = 1'b0;
    memAddress   = '0;
    memWriteData = '0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (m0Req && m1Req) begin
`ifdef BANKMEM_ARB_RR_EN
            m0Gnt = last_gnt_q;
            m1Gnt = !last_gnt_q;
`else
            m0Gnt = 1'b1;
`endif
          end else begin
            m0Gnt = m0Req;
            m1Gnt = m1Req;
          end
        end
        OWN0:    m0Gnt = m0Req;
        OWN1:    m1Gnt = m1Req;
        default: ;
      endcase
    end
    if (m0Gnt) begin
      memWriteEn   = m0WriteEn;
      memAddress   = m0Address;
      memWriteData = m0WriteData;
    end else if (m1Gnt) begin
      memWriteEn   = m1WriteEn;
      memAddress   = m1Address;
      memWriteData = m1WriteData;
    end
  end

  assign lock_cnt_inc = lock_cnt_q + CNT_W'(1);

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    lock_cnt_d  = lock_cnt_q;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;

    if (m0Gnt) begin
      last_gnt_d = 1'b0;
      if (!m0WriteEn) begin
        m0_rvalid_d = 1'b1;
        m0_rdata_d  = memReadData;
      end
    end
    if (m1Gnt) begin
      last_gnt_d = 1'b1;
      if (!m1WriteEn) begin
        m1_rvalid_d = 1'b1;
        m1_rdata_d  = memReadData;
      end
    end

    case (state_q)
      IDLE: begin
        lock_cnt_d = '0;
        if (m0Gnt && m0Lock) begin
          state_d    = OWN0;
          lock_cnt_d = CNT_W'(1);
        end else if (m1Gnt && m1Lock) begin
          state_d    = OWN1;
          lock_cnt_d = CNT_W'(1);
        end
      end
      OWN0: begin
        lock_cnt_d = lock_cnt_inc;
        if ((m0Gnt && !m0Lock) || (!m0Req && !m0Lock)) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else if (lock_cnt_inc == CNT_MAX) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
          last_gnt_d = 1'b0;
        end
      end
      OWN1: begin
        lock_cnt_d = lock_cnt_inc;
        if ((m1Gnt && !m1Lock) || (!m1Req && !m1Lock)) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else if (lock_cnt_inc == CNT_MAX) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
          last_gnt_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  assign m0RValid = m0_rvalid_q;
  assign m1RValid = m1_rvalid_q;
  assign m0RData  = m0_rdata_q;
  assign m1RData  = m1_rdata_q;

endmodule

// File: tb/tb_bankmem_arbiter.sv
// Scoreboard bench for bankmem_arbiter: the driver queues expected grants and read data,
// a negedge monitor pops and compares them against the DUT, alongside a small memory model.
module tb_bankmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0Req, m0WriteEn, m0Lock;
  logic [31:0] m0Address, m0WriteData;
  logic        m1Req, m1WriteEn, m1Lock;
  logic [31:0] m1Address, m1WriteData;
  logic        m0Gnt, m1Gnt, m0RValid, m1RValid;
  logic [31:0] m0RData, m1RData;
  logic        memWriteEn;
  logic [31:0] memAddress, memWriteData, memReadData;

  logic [31:0] mem [0:15];
  logic        mem_clr;
  logic        mon_en = 1'b0;

  typedef struct {
    logic [1:0]  gnt;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } gexp_t;

  gexp_t       gq[$];
  logic [31:0] rq0[$];
  logic [31:0] rq1[$];
  int          checks   = 0;
  int          failures = 0;

`ifdef BANKMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  bankmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0Req(m0Req), .m0WriteEn(m0WriteEn), .m0Lock(m0Lock),
    .m0Address(m0Address), .m0WriteData(m0WriteData),
    .m1Req(m1Req), .m1WriteEn(m1WriteEn), .m1Lock(m1Lock),
    .m1Address(m1Address), .m1WriteData(m1WriteData),
    .m0Gnt(m0Gnt), .m1Gnt(m1Gnt),
    .m0RValid(m0RValid), .m1RValid(m1RValid),
    .m0RData(m0RData), .m1RData(m1RData),
    .memWriteEn(memWriteEn), .memAddress(memAddress),
    .memWriteData(memWriteData), .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  // BankedMEM stand-in: combinational read, write committed at the edge
  assign memReadData = mem[memAddress[5:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (memWriteEn) begin
      mem[memAddress[5:2]] <= memWriteData;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drv0(input logic req, input logic we, input logic lock,
                      input logic [31:0] addr, input logic [31:0] wd);
    m0Req = req; m0WriteEn = we; m0Lock = lock; m0Address = addr; m0WriteData = wd;
  endtask

  task automatic drv1(input logic req, input logic we, input logic lock,
                      input logic [31:0] addr, input logic [31:0] wd);
    m1Req = req; m1WriteEn = we; m1Lock = lock; m1Address = addr; m1WriteData = wd;
  endtask

  // Queue the expected outcome of the cycle whose inputs are currently driven
  task automatic expect_cycle(input logic [1:0] g, input logic [31:0] rd, input bit rd_ok);
    gexp_t e;
    e.gnt = g; e.we = 1'b0; e.addr = 32'h0; e.wd = 32'h0;
    if (g[0]) begin
      e.we = m0WriteEn; e.addr = m0Address; e.wd = m0WriteData;
      if (!m0WriteEn && rd_ok) rq0.push_back(rd);
    end else if (g[1]) begin
      e.we = m1WriteEn; e.addr = m1Address; e.wd = m1WriteData;
      if (!m1WriteEn && rd_ok) rq1.push_back(rd);
    end
    gq.push_back(e);
  endtask

  task automatic step(input logic [1:0] g, input logic [31:0] rd);
    expect_cycle(g, rd, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    drv0(0, 0, 0, 32'h0, 32'h0);
    drv1(0, 0, 0, 32'h0, 32'h0);
  endtask

  // Monitor
  always @(negedge clk) begin
    gexp_t e;
    if (mon_en) begin
      if (gq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL gnt_queue: got empty expected entry");
      end else begin
        e = gq.pop_front();
        chk("gnt", 64'({m1Gnt, m0Gnt}), 64'(e.gnt));
        chk("mem_we", 64'(memWriteEn), 64'(e.we));
        chk("mem_addr", 64'(memAddress), 64'(e.addr));
        chk("mem_wdata", 64'(memWriteData), 64'(e.wd));
      end
      if (m0RValid) begin
        if (rq0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL m0_rvalid: got 1 expected 0");
        end else begin
          chk("m0_rdata", 64'(m0RData), 64'(rq0.pop_front()));
        end
      end
      if (m1RValid) begin
        if (rq1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL m1_rvalid: got 1 expected 0");
        end else begin
          chk("m1_rdata", 64'(m1RData), 64'(rq1.pop_front()));
        end
      end
      $display("txn t=%0t gnt=%b%b we=%b addr=0x%0h wd=0x%0h rv=%b%b rd0=0x%0h rd1=0x%0h",
               $time, m1Gnt, m0Gnt, memWriteEn, memAddress, memWriteData,
               m1RValid, m0RValid, m0RData, m1RData);
    end
  end

  initial begin
    logic [31:0] mem4;

    // Reset with both masters requesting writes: nothing may be granted
    rst_n   = 1'b0;
    mem_clr = 1'b1;
    drv0(1, 1, 0, 32'h0, 32'hAAAA_AAAA);
    drv1(1, 1, 0, 32'h4, 32'hBBBB_BBBB);
    #1;
    chk("rst_m0gnt", 64'(m0Gnt), 64'd0);
    chk("rst_m1gnt", 64'(m1Gnt), 64'd0);
    chk("rst_memwe", 64'(memWriteEn), 64'd0);
    chk("rst_rvalid", 64'({m1RValid, m0RValid}), 64'd0);
    chk("rst_m0rdata", 64'(m0RData), 64'd0);
    chk("rst_m1rdata", 64'(m1RData), 64'd0);
    @(posedge clk);
    #1;
    mem_clr = 1'b0;
    idle_all();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // m0 write then read back
    drv0(1, 1, 0, 32'h0, 32'hDEAD_BEEF); step(2'b01, 32'h0);
    drv0(1, 0, 0, 32'h0, 32'h0);         step(2'b01, 32'hDEAD_BEEF);

    // Contention for 4 cycles; lastGnt is 0 after the m0 read
    drv0(1, 0, 0, 32'h0, 32'h0);
    drv1(1, 1, 0, 32'h4, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      if (RR) step((i % 2 == 0) ? 2'b10 : 2'b01, 32'hDEAD_BEEF);
      else    step(2'b01, 32'hDEAD_BEEF);
    end
    idle_all(); step(2'b00, 32'h0);
    mem4 = RR ? 32'h1234_5678 : 32'h0;

    // m1 locked read-modify-write; m0 stalls even while m1 pauses
    drv1(1, 0, 1, 32'h4, 32'h0);          step(2'b10, mem4);
    drv0(1, 0, 0, 32'h0, 32'h0);
    drv1(0, 0, 1, 32'h4, 32'h0);          step(2'b00, 32'h0);
    drv1(1, 1, 0, 32'h4, 32'h1234_5679);  step(2'b10, 32'h0);
    drv1(0, 0, 0, 32'h0, 32'h0);          step(2'b01, 32'hDEAD_BEEF);

    // m0 holds the lock: forced release after 8 granted cycles
    drv0(1, 0, 1, 32'h4, 32'h0);
    drv1(0, 0, 0, 32'h0, 32'h0);          step(2'b01, 32'h1234_5679);
    drv1(1, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 7; i++) step(2'b01, 32'h1234_5679);
    if (RR) step(2'b10, 32'hDEAD_BEEF);
    else    step(2'b01, 32'h1234_5679);
    step(2'b01, 32'h1234_5679);
    drv0(0, 0, 0, 32'h0, 32'h0);          step(2'b00, 32'h0);
    step(2'b10, 32'hDEAD_BEEF);
    idle_all();

    // Reset during an OWN0 read discards the pending response
    drv0(1, 0, 1, 32'h0, 32'h0);          step(2'b01, 32'hDEAD_BEEF);
    drv0(1, 0, 1, 32'h4, 32'h0);
    drv1(1, 0, 0, 32'h0, 32'h0);
    expect_cycle(2'b01, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 64'({m1Gnt, m0Gnt}), 64'd0);
    chk("midrst_memwe", 64'(memWriteEn), 64'd0);
    chk("midrst_rvalid", 64'(m0RValid), 64'd0);
    @(posedge clk);
    #1;
    chk("postrst_m0rdata", 64'(m0RData), 64'd0);
    rst_n = 1'b1;
    drv0(0, 0, 1, 32'h0, 32'h0);          step(2'b10, 32'hDEAD_BEEF);

    // Simultaneous reads: each master gets its own response on its grant
    drv0(1, 0, 0, 32'h4, 32'h0);
    drv1(1, 0, 0, 32'h0, 32'h0);          step(2'b01, 32'h1234_5679);
    drv0(0, 0, 0, 32'h0, 32'h0);          step(2'b10, 32'hDEAD_BEEF);
    idle_all();
    for (int i = 0; i < 3; i++) step(2'b00, 32'h0);
    mon_en = 1'b0;

    chk("gq_drained", 64'(gq.size()), 64'd0);
    chk("rq0_drained", 64'(rq0.size()), 64'd0);
    chk("rq1_drained", 64'(rq1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
